sram_timing_monitor: RTL and testbench

- Synthesizable, parametrised monitor for an asynchronous SRAM bus with NB byte lanes.
- Sits in parallel with the SRAM pins (sampled in the controller clock domain) and tracks read and write cycles with a phase state machine.
- Checks cycle-count timing rules, reports sticky violation flags, a saturating violation count and the first-error code.
- Provides o_rd_valid, which marks samples where read data is guaranteed valid.

---
 rtl/sram_mon_pkg.sv | 31 +++
 rtl/sram_stable_counter.sv | 30 +++
 rtl/sram_timing_monitor.sv | 169 ++++++++++++++++
 tb/tb_sram_timing_monitor.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sram_mon_pkg.sv
// Shared types and constants for the asynchronous SRAM bus timing monitor.
// Error-bit indices double as the priority order for first-error capture.
package sram_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RECOVER
  } state_t;

  localparam int NERR   = 8;
  localparam int E_RC   = 0;
  localparam int E_AS   = 1;
  localparam int E_ADDR = 2;
  localparam int E_PWE  = 3;
  localparam int E_SD   = 4;
  localparam int E_HD   = 5;
  localparam int E_WC   = 6;
  localparam int E_BE   = 7;

  function automatic logic [2:0] lowest_set(input logic [NERR-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NERR - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sram_stable_counter.sv
// Change detector plus saturating stability counter for one sampled bus field.
// o_stable is the stability of the current sample: 0 when it differs from the previous one.
module sram_stable_counter #(
  parameter int W  = 1,
  parameter int CW = 5
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [W-1:0]  i_value,
  output logic          o_changed,
  output logic [CW-1:0] o_stable
);

  logic [W-1:0]  prev_q;
  logic [CW-1:0] count_q;

  assign o_changed = (i_value != prev_q);
  assign o_stable  = o_changed ? '0 : ((&count_q) ? count_q : count_q + 1'b1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_q  <= '0;
      count_q <= '0;
    end else begin
      prev_q  <= i_value;
      count_q <= o_stable;
    end
  end

endmodule

// File: rtl/sram_timing_monitor.sv
// Passive timing monitor for an asynchronous SRAM bus: phase FSM, timing-rule checks,
// sticky error flags, saturating violation count and first-error capture. DW must be a multiple of 8.
module sram_timing_monitor
  import sram_mon_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int NB     = DW / 8,
  parameter int CW     = 5,
  parameter int ERRW   = 16,
  parameter int CK_AA  = 2,
  parameter int CK_RC  = 2,
  parameter int CK_AS  = 1,
  parameter int CK_PWE = 1,
  parameter int CK_SD  = 1,
  parameter int CK_HD  = 0,
  parameter int CK_WC  = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_clear,
  input  logic            i_ce_n,
  input  logic            i_oe_n,
  input  logic            i_we_n,
  input  logic [NB-1:0]   i_be_n,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_data,
  output logic            o_rd_valid,
  output logic [7:0]      o_err,
  output logic [ERRW-1:0] o_err_count,
  output logic [2:0]      o_first_err,
  output logic            o_first_valid
);

  logic          addr_chg, data_chg, ctrl_chg;
  logic [CW-1:0] addr_stab, data_stab, ctrl_stab;

  sram_stable_counter #(.W(AW + NB), .CW(CW)) u_addr_stab (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_value   ({i_addr, i_be_n}),
    .o_changed (addr_chg),
    .o_stable  (addr_stab)
  );

  sram_stable_counter #(.W(DW), .CW(CW)) u_data_stab (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_value   (i_data),
    .o_changed (data_chg),
    .o_stable  (data_stab)
  );

  sram_stable_counter #(.W(3), .CW(CW)) u_ctrl_stab (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_value   ({i_ce_n, i_oe_n, i_we_n}),
    .o_changed (ctrl_chg),
    .o_stable  (ctrl_stab)
  );

  state_t        state_q, state_d, idle_next;
  logic [CW-1:0] phase_q, phase_d, wc_q;
  logic          prev_we_n_q, seen_write_q;
  logic          we_fall, entering_write, leaving_write;
  logic [NERR-1:0] err_vec;
  int            phase_i, wc_i;

  assign we_fall = prev_we_n_q && !i_we_n;
  assign phase_i = int'(phase_q);
  assign wc_i    = int'(wc_q);

  always_comb begin
    idle_next = IDLE;
    state_d   = state_q;
    if (!i_ce_n) idle_next = i_we_n ? READ : WRITE;
    case (state_q)
      IDLE:    state_d = idle_next;
      READ: begin
        if (i_ce_n)      state_d = IDLE;
        else if (!i_we_n) state_d = WRITE;
      end
      WRITE:   if (i_we_n || i_ce_n) state_d = RECOVER;
      RECOVER: begin
        if (phase_i >= CK_HD)          state_d = idle_next;
        else if (we_fall && !i_ce_n)   state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase restarts on every state change and, while idle or reading, on each address change.
  always_comb begin
    phase_d = (&phase_q) ? phase_q : phase_q + 1'b1;
    if (state_d != state_q) phase_d = '0;
    else if ((state_q == IDLE || state_q == READ) && addr_chg) phase_d = '0;
  end

  always_comb begin
    entering_write = (state_d == WRITE) && (state_q != WRITE);
    leaving_write  = (state_q == WRITE) && (state_d != WRITE);
    err_vec         = '0;
    err_vec[E_RC]   = (state_q == READ) && addr_chg && (phase_i < CK_RC);
    err_vec[E_AS]   = entering_write && (int'(addr_stab) < CK_AS);
    err_vec[E_ADDR] = (state_q == WRITE) && addr_chg;
    err_vec[E_PWE]  = leaving_write && (phase_i + 1 < CK_PWE);
    err_vec[E_SD]   = leaving_write && (int'(data_stab) < CK_SD);
    err_vec[E_HD]   = (state_q == RECOVER) && data_chg && (phase_i < CK_HD);
    err_vec[E_WC]   = entering_write && (state_q == RECOVER || state_q == READ)
                      && seen_write_q && (wc_i < CK_WC);
    err_vec[E_BE]   = (state_q == WRITE) && (&i_be_n);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      wc_q         <= '0;
      prev_we_n_q  <= 1'b1;
      seen_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wc_q        <= we_fall ? '0 : ((&wc_q) ? wc_q : wc_q + 1'b1);
      prev_we_n_q <= i_we_n;
      if (entering_write) seen_write_q <= 1'b1;
    end
  end

  // Clear acts first so a violation in the same sample is recorded into the fresh state.
  logic [7:0]      err_d;
  logic [ERRW-1:0] count_d;
  logic [2:0]      first_err_d;
  logic            first_valid_d, rd_valid_d;

  always_comb begin
    err_d         = i_clear ? '0 : o_err;
    count_d       = i_clear ? '0 : o_err_count;
    first_valid_d = i_clear ? 1'b0 : o_first_valid;
    first_err_d   = o_first_err;
    err_d         = err_d | err_vec;
    if (|err_vec) begin
      if (!(&count_d)) count_d = count_d + 1'b1;
      if (!first_valid_d) begin
        first_err_d   = lowest_set(err_vec);
        first_valid_d = 1'b1;
      end
    end
    rd_valid_d = (state_q == READ) && !i_ce_n && !i_oe_n && i_we_n && !(&i_be_n)
                 && (int'(addr_stab) >= CK_AA) && (int'(ctrl_stab) >= CK_AA);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rd_valid    <= 1'b0;
      o_err         <= '0;
      o_err_count   <= '0;
      o_first_err   <= '0;
      o_first_valid <= 1'b0;
    end else begin
      o_rd_valid    <= rd_valid_d;
      o_err         <= err_d;
      o_err_count   <= count_d;
      o_first_err   <= first_err_d;
      o_first_valid <= first_valid_d;
    end
  end

endmodule

// File: tb/tb_sram_timing_monitor.sv
// Directed bench for sram_timing_monitor with CK_PWE=3, CK_HD=2 and a 2-bit error counter.
module tb_sram_timing_monitor;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int NB   = 2;
  localparam int ERRW = 2;

  logic            i_clk     = 1'b0;
  logic            i_reset_n = 1'b0;
  logic            i_clear   = 1'b0;
  logic            i_ce_n    = 1'b1;
  logic            i_oe_n    = 1'b1;
  logic            i_we_n    = 1'b1;
  logic [NB-1:0]   i_be_n    = '0;
  logic [AW-1:0]   i_addr    = '0;
  logic [DW-1:0]   i_data    = '0;
  logic            o_rd_valid;
  logic [7:0]      o_err;
  logic [ERRW-1:0] o_err_count;
  logic [2:0]      o_first_err;
  logic            o_first_valid;

  int checkCount = 0;
  int errorCount = 0;

  always #5 i_clk = ~i_clk;

  sram_timing_monitor #(
    .AW(AW), .DW(DW), .NB(NB), .CW(5), .ERRW(ERRW),
    .CK_AA(2), .CK_RC(2), .CK_AS(1), .CK_PWE(3), .CK_SD(1), .CK_HD(2), .CK_WC(2)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_clear       (i_clear),
    .i_ce_n        (i_ce_n),
    .i_oe_n        (i_oe_n),
    .i_we_n        (i_we_n),
    .i_be_n        (i_be_n),
    .i_addr        (i_addr),
    .i_data        (i_data),
    .o_rd_valid    (o_rd_valid),
    .o_err         (o_err),
    .o_err_count   (o_err_count),
    .o_first_err   (o_first_err),
    .o_first_valid (o_first_valid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one bus sample at the falling edge and returns one cycle later, after the DUT has registered it.
  task automatic applyStimulus(input logic ce, input logic oe, input logic we, input logic [NB-1:0] be,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic clr);
    i_ce_n  = ce;
    i_oe_n  = oe;
    i_we_n  = we;
    i_be_n  = be;
    i_addr  = addr;
    i_data  = data;
    i_clear = clr;
    @(negedge i_clk);
  endtask

  task automatic checkFlags(input string tag, input logic [7:0] err, input logic [ERRW-1:0] cnt,
                            input logic [2:0] first, input logic fvalid);
    checkOutput({tag, "_err"},   32'(o_err),         32'(err));
    checkOutput({tag, "_count"}, 32'(o_err_count),   32'(cnt));
    checkOutput({tag, "_fv"},    32'(o_first_valid), 32'(fvalid));
    if (fvalid) checkOutput({tag, "_first"}, 32'(o_first_err), 32'(first));
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;

    // Reset mid-write: an E_AS flag must vanish as soon as reset is asserted
    repeat (3) applyStimulus(1, 1, 1, 2'b00, 16'h0000, 16'h0000, 0);
    checkFlags("idle", 8'h00, 2'd0, 3'd0, 1'b0);
    applyStimulus(0, 1, 0, 2'b00, 16'h0010, 16'h0000, 0);
    checkFlags("as", 8'h02, 2'd1, 3'd1, 1'b1);
    #2 i_reset_n = 1'b0;
    #1 checkFlags("rst_async", 8'h00, 2'd0, 3'd0, 1'b0);
    checkOutput("rst_rdv", 32'(o_rd_valid), 32'd0);
    i_ce_n = 1'b1;
    i_we_n = 1'b1;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) applyStimulus(1, 1, 1, 2'b00, 16'h0010, 16'h1234, 0);
    checkFlags("post_rst", 8'h00, 2'd0, 3'd0, 1'b0);

    // Clean read: valid from the third registered sample
    applyStimulus(0, 0, 1, 2'b00, 16'h0020, 16'h1234, 0);
    checkOutput("rd0", 32'(o_rd_valid), 32'd0);
    applyStimulus(0, 0, 1, 2'b00, 16'h0020, 16'h1234, 0);
    checkOutput("rd1", 32'(o_rd_valid), 32'd0);
    applyStimulus(0, 0, 1, 2'b00, 16'h0020, 16'h1234, 0);
    checkOutput("rd2", 32'(o_rd_valid), 32'd1);
    applyStimulus(0, 0, 1, 2'b00, 16'h0020, 16'h1234, 0);
    checkOutput("rd3", 32'(o_rd_valid), 32'd1);
    checkOutput("rd_err", 32'(o_err), 32'd0);
    applyStimulus(1, 1, 1, 2'b00, 16'h0020, 16'h1234, 0);
    checkOutput("rd_end", 32'(o_rd_valid), 32'd0);

    // Write with WE low for only two samples
    applyStimulus(1, 1, 1, 2'b00, 16'h0020, 16'h1234, 0);
    applyStimulus(0, 1, 0, 2'b00, 16'h0020, 16'h1234, 0);
    applyStimulus(0, 1, 0, 2'b00, 16'h0020, 16'h1234, 0);
    checkOutput("pwe_pre", 32'(o_err), 32'd0);
    applyStimulus(1, 1, 1, 2'b00, 16'h0020, 16'h1234, 0);
    checkFlags("pwe", 8'h08, 2'd1, 3'd3, 1'b1);
    repeat (3) applyStimulus(1, 1, 1, 2'b00, 16'h0020, 16'h1234, 0);
    checkOutput("pwe_sticky", 32'(o_err), 32'h08);

    // Address and byte-enable fault in the same write sample
    applyStimulus(1, 1, 1, 2'b00, 16'h0020, 16'h1234, 1);
    checkFlags("clr1", 8'h00, 2'd0, 3'd0, 1'b0);
    applyStimulus(0, 1, 0, 2'b00, 16'h0020, 16'h1234, 0);
    applyStimulus(0, 1, 0, 2'b11, 16'h0024, 16'h1234, 0);
    checkFlags("addr_be", 8'h84, 2'd1, 3'd2, 1'b1);
    applyStimulus(1, 1, 1, 2'b11, 16'h0024, 16'h1234, 0);
    checkFlags("be_pwe", 8'h8C, 2'd2, 3'd2, 1'b1);
    repeat (3) applyStimulus(1, 1, 1, 2'b11, 16'h0024, 16'h1234, 0);
    repeat (2) applyStimulus(1, 1, 1, 2'b00, 16'h0024, 16'h1234, 0);
    applyStimulus(1, 1, 1, 2'b00, 16'h0024, 16'h1234, 1);
    checkFlags("clr2", 8'h00, 2'd0, 3'd0, 1'b0);

    // Data setup then data hold faults around the WE rise
    repeat (3) applyStimulus(0, 1, 0, 2'b00, 16'h0024, 16'h1234, 0);
    applyStimulus(0, 1, 1, 2'b00, 16'h0024, 16'hBEEF, 0);
    checkFlags("sd", 8'h10, 2'd1, 3'd4, 1'b1);
    applyStimulus(0, 1, 1, 2'b00, 16'h0024, 16'hCAFE, 0);
    checkFlags("hd", 8'h30, 2'd2, 3'd4, 1'b1);
    repeat (2) applyStimulus(0, 1, 1, 2'b00, 16'h0024, 16'hCAFE, 0);
    applyStimulus(1, 1, 1, 2'b00, 16'h0024, 16'hCAFE, 0);
    checkFlags("hd_hold", 8'h30, 2'd2, 3'd4, 1'b1);

    // Read-cycle violations saturate the 2-bit counter; clear coincides with one
    applyStimulus(1, 1, 1, 2'b00, 16'h0024, 16'hCAFE, 1);
    checkFlags("clr3", 8'h00, 2'd0, 3'd0, 1'b0);
    applyStimulus(0, 0, 1, 2'b00, 16'h0024, 16'hCAFE, 0);
    applyStimulus(0, 0, 1, 2'b00, 16'h0030, 16'hCAFE, 0);
    checkFlags("rc1", 8'h01, 2'd1, 3'd0, 1'b1);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(0, 0, 1, 2'b00, 16'h0030 + 16'(i), 16'hCAFE, 0);
    end
    checkFlags("rc_sat", 8'h01, 2'd3, 3'd0, 1'b1);
    applyStimulus(0, 0, 1, 2'b00, 16'h0035, 16'hCAFE, 1);
    checkFlags("clr_rc", 8'h01, 2'd1, 3'd0, 1'b1);
    applyStimulus(0, 0, 1, 2'b00, 16'h0035, 16'hCAFE, 0);
    checkFlags("rc_quiet", 8'h01, 2'd1, 3'd0, 1'b1);
    checkOutput("rc_rdv0", 32'(o_rd_valid), 32'd0);
    applyStimulus(0, 0, 1, 2'b00, 16'h0035, 16'hCAFE, 1);
    checkFlags("clr4", 8'h00, 2'd0, 3'd0, 1'b0);
    checkOutput("rc_rdv1", 32'(o_rd_valid), 32'd1);

    applyStimulus(1, 1, 1, 2'b00, 16'h0035, 16'hCAFE, 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
